sync_fifo_flex: RTL

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

---
 rtl/fifo_pkg.sv | 16 +
 rtl/sfifo_ram.sv | 55 +++++
 rtl/sync_fifo_flex.sv | 99 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, read-mode enum and pointer-width helper for the synchronous FIFO.
package fifo_pkg;

    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_DATA_SIZE = 8;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } read_mode_e;

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Single-clock storage array: one write port, one read port whose timing depends on the read mode.
module sfifo_ram #(
    parameter int                   DEPTH     = fifo_pkg::DEFAULT_DEPTH,
    parameter int                   DATA_SIZE = fifo_pkg::DEFAULT_DATA_SIZE,
    parameter int                   ADDR_SIZE = fifo_pkg::ptr_width(DEPTH),
    parameter fifo_pkg::read_mode_e MODE      = fifo_pkg::STD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic                 valid,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);
    import fifo_pkg::*;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (MODE == STD) begin : g_std
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata <= '0;
                end else if (re && valid) begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_fwft
            logic [DATA_SIZE-1:0] hold;

            // Track the word on display so the output stays put once the FIFO drains or is flushed.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold <= '0;
                end else if (valid) begin
                    hold <= mem[raddr];
                end
            end

            always_comb begin
                rdata = valid ? mem[raddr] : hold;
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with registered status flags, error pulses, flush and selectable read latency.
module sync_fifo_flex #(
    parameter int DEPTH     = fifo_pkg::DEFAULT_DEPTH,
    parameter int DATA_SIZE = fifo_pkg::DEFAULT_DATA_SIZE,
    parameter int PTR_SIZE  = fifo_pkg::ptr_width(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 w_en,
    input  logic                 r_en,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_SIZE:0]    count,
    output logic                 write_error,
    output logic                 read_error
);
    import fifo_pkg::*;

    localparam read_mode_e         MODE       = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
    localparam logic [PTR_SIZE:0]  FULL_LEVEL = (PTR_SIZE + 1)'(DEPTH);
    localparam logic [PTR_SIZE:0]  AF_LEVEL   = (PTR_SIZE + 1)'(AF_THRESH);
    localparam logic [PTR_SIZE:0]  AE_LEVEL   = (PTR_SIZE + 1)'(AE_THRESH);

    logic [PTR_SIZE-1:0] wptr;
    logic [PTR_SIZE-1:0] rptr;
    logic [PTR_SIZE:0]   count_next;
    logic                wr_ok;
    logic                rd_ok;

    always_comb begin
        wr_ok = w_en && !full && !flush;
        rd_ok = r_en && !empty && !flush;

        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (wr_ok && !rd_ok) begin
            count_next = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Flags are registered from count_next so they change on the same edge as count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            write_error  <= 1'b0;
            read_error   <= 1'b0;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_ok) wptr <= wptr + 1'b1;
                if (rd_ok) rptr <= rptr + 1'b1;
            end
            count        <= count_next;
            full         <= (count_next == FULL_LEVEL);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_LEVEL);
            almost_empty <= (count_next <= AE_LEVEL);
            write_error  <= w_en && full && !flush;
            read_error   <= r_en && empty && !flush;
        end
    end

    sfifo_ram #(
        .DEPTH     (DEPTH),
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (PTR_SIZE),
        .MODE      (MODE)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (data_in),
        .re    (rd_ok),
        .valid (!empty),
        .raddr (rptr),
        .rdata (data_out)
    );

endmodule
